serial_twos_comp_unit: RTL
==========================

// Module: serial_twos_comp_unit
// PURPOSE
//  Bit-serial, LSB-first two's-complement unit with a parametrised word width and
//  a per-word mode: pass, negate or absolute value.
//  Buffers one full word so the sign is known before output.
//  Streams the result out one bit per cycle with framing and overflow flags.
//  Sits between serial sources and serial arithmetic stages.
// PARAMETERS
//  WIDTH       8  word length in bits (>=2)
//  AUTO_FRAME  0  1: a valid bit after a completed word starts a new word without i_first
// PORTS
//  t_clk    in   1  clock, rising edge
//  r        in   1  synchronous active-high reset
//  i_valid  in   1  i carries a data bit this cycle
//  i        in   1  serial data bit, LSB first
//  i_first  in   1  qualifies a valid bit as the LSB of a new word
//  mode     in   2  sampled with the i_first bit: 00 pass, 01 negate, 10 abs, 11 pass
//  y        out  1  serial result bit, LSB first
//  y_valid  out  1  y holds a result bit
//  y_first  out  1  y is the LSB of a result word
//  y_last   out  1  y is the MSB of a result word
//  ovf      out  1  with y_last: result not representable (negate/abs of -2^(WIDTH-1))
//  frame_err out 1  one-cycle pulse: a word was aborted by i_first mid-word
// BEHAVIOUR
//  Reset
//   - While r=1 at an edge, all outputs go to 0 from the next cycle.
//   - Both FSMs go idle, counters are zeroed, and any in-flight word is lost.
//   - r overrides every other input in the same cycle.
//  Input FSM
//   - WAIT_FIRST: a valid bit with i_first=1 is stored as bit 0, latches mode,
//     and moves to RECV with bit count 1.
//   - WAIT_FIRST: a valid bit with i_first=0 is dropped, unless AUTO_FRAME=1 and a
//     word has completed since reset. In that case it starts a word with the
//     previous mode.
//   - RECV: each valid bit shifts into the input register.
//   - RECV: i_first=1 with count<WIDTH discards the partial word, pulses frame_err
//     the next cycle, and restarts the word with this bit as bit 0 and the new mode.
//   - RECV: on the WIDTH-th bit, the word, mode, MSB and ovf condition are
//     transferred to the output register, and the FSM returns to WAIT_FIRST.
//     ovf condition: MSB=1, other bits 0, mode 01/10.
//   - i_valid=0 cycles: state and counter hold, so gaps are allowed.
//  Output FSM
//   - OUT_IDLE -> OUT_SEND on transfer.
//   - OUT_SEND emits WIDTH consecutive bits, one per cycle, then returns to
//     OUT_IDLE unless a new transfer lands on its last cycle. In that case it
//     continues seamlessly.
//   - Negation rule: y = b XOR seen_one. seen_one clears at each word start and
//     sets after the first emitted 1 of the source bit b.
//   - Applied for mode 01, or for mode 10 when the latched MSB=1. Otherwise y = b.
//  Timing
//   - Latency: y_valid/y_first assert on the cycle after the edge that captured
//     the last input bit.
//   - The input needs >=WIDTH cycles per word, so transfer never overruns an
//     active output word. No backpressure.
//  Outputs
//   - y_first, y_last and ovf are 0 whenever y_valid=0. ovf is only meaningful
//     on the y_last cycle.
//  Widths
//   - Bit counters are $clog2(WIDTH+1) bits wide and wrap only through word
//     completion.
// TESTING
//  - WIDTH=8, mode 01, send 0x05 (bits 1,0,1,0,0,0,0,0):
//    y = 1,1,0,1,1,1,1,1 (0xFB); y_first on bit 0, y_last on bit 7; ovf=0; first
//    y one cycle after the last input bit.
//  - Mode 10, send 0xF6:
//    y = 0x0A. Then mode 10, send 0x0A: y = 0x0A unchanged. Mode 00, send 0xF6:
//    y = 0xF6.
//  - Mode 01, send 0x80:
//    y = 0x80 with ovf=1 on y_last. Mode 01, send 0x00: y = 0x00, ovf=0.
//  - Two words back to back, i_valid held high:
//    the second word's y_first follows the first's y_last with no gap. Repeat with
//    random i_valid gaps: results are identical.
//  - i_first asserted on bit 3 of a word:
//    frame_err pulses once, no output for the partial word, the new 8-bit word is
//    processed correctly.
//  - r asserted during bit 4 of an output word:
//    all outputs 0 next cycle. Bits sent without i_first are dropped
//    (AUTO_FRAME=0). The next framed word is correct.

Source files
------------

// File: rtl/serial_twos_comp_unit.sv
// serial_twos_comp_unit: bit-serial LSB-first pass/negate/abs unit with one-word buffering
module serial_twos_comp_unit #(
  parameter int WIDTH      = 8,
  parameter bit AUTO_FRAME = 1'b0
) (
  input  logic       t_clk,
  input  logic       r,
  input  logic       i_valid,
  input  logic       i,
  input  logic       i_first,
  input  logic [1:0] mode,
  output logic       y,
  output logic       y_valid,
  output logic       y_first,
  output logic       y_last,
  output logic       ovf,
  output logic       frame_err
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {WAIT_FIRST, RECV} in_state_t;
  typedef enum logic {OUT_IDLE, OUT_SEND} out_state_t;
  in_state_t        in_state_q, in_state_d;
  out_state_t       out_state_q, out_state_d;
  logic [WIDTH-2:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d, ocnt_q, ocnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             done_q, done_d, fe_q, fe_d;
  logic [WIDTH-1:0] oreg_q, oreg_d, word;
  logic             neg_q, neg_d, seen_q, seen_d, ovf_q, ovf_d;
  logic             start, restart, shift, xfer, olast;
  always_ff @(posedge t_clk) begin
    if (r) begin
      in_state_q  <= WAIT_FIRST;
      out_state_q <= OUT_IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      ocnt_q      <= '0;
      mode_q      <= '0;
      done_q      <= 1'b0;
      fe_q        <= 1'b0;
      oreg_q      <= '0;
      neg_q       <= 1'b0;
      seen_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      ocnt_q      <= ocnt_d;
      mode_q      <= mode_d;
      done_q      <= done_d;
      fe_q        <= fe_d;
      oreg_q      <= oreg_d;
      neg_q       <= neg_d;
      seen_q      <= seen_d;
      ovf_q       <= ovf_d;
    end
  end
  // The incoming bit completes the word; earlier bits were shifted in from the top.
  assign word    = {i, sreg_q};
  assign start   = i_valid && in_state_q == WAIT_FIRST && (i_first || (AUTO_FRAME && done_q));
  assign restart = i_valid && in_state_q == RECV && i_first;
  assign shift   = i_valid && in_state_q == RECV && !i_first;
  assign xfer    = shift && cnt_q == CW'(WIDTH - 1);
  assign olast   = out_state_q == OUT_SEND && ocnt_q == CW'(WIDTH - 1);
  always_comb begin
    in_state_d = in_state_q;
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    done_d     = done_q | xfer;
    fe_d       = restart;
    if (start || restart) begin
      in_state_d = RECV;
      sreg_d     = word[WIDTH-1:1];
      cnt_d      = CW'(1);
      mode_d     = i_first ? mode : mode_q;
    end else if (shift) begin
      in_state_d = xfer ? WAIT_FIRST : RECV;
      sreg_d     = word[WIDTH-1:1];
      cnt_d      = xfer ? '0 : cnt_q + CW'(1);
    end
  end
  // A transfer on the last output cycle reloads the shifter so words stream without a gap.
  always_comb begin
    out_state_d = out_state_q;
    oreg_d      = oreg_q;
    ocnt_d      = ocnt_q;
    neg_d       = neg_q;
    seen_d      = seen_q;
    ovf_d       = ovf_q;
    if (xfer) begin
      out_state_d = OUT_SEND;
      oreg_d      = word;
      ocnt_d      = '0;
      neg_d       = mode_q == 2'b01 || (mode_q == 2'b10 && word[WIDTH-1]);
      seen_d      = 1'b0;
      ovf_d       = (mode_q[0] ^ mode_q[1]) && word == {1'b1, {(WIDTH-1){1'b0}}};
    end else if (out_state_q == OUT_SEND) begin
      out_state_d = olast ? OUT_IDLE : OUT_SEND;
      oreg_d      = oreg_q >> 1;
      ocnt_d      = olast ? '0 : ocnt_q + CW'(1);
      seen_d      = seen_q | oreg_q[0];
    end
  end
  always_comb begin
    y_valid   = out_state_q == OUT_SEND;
    y         = y_valid & (oreg_q[0] ^ (neg_q & seen_q));
    y_first   = y_valid && ocnt_q == '0;
    y_last    = olast;
    ovf       = olast & ovf_q;
    frame_err = fe_q;
  end
endmodule
